// File: rtl/arb2_mux.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Bounded tenure: a holder is preempted after MAX_HOLD cycles if the peer waits.
module arb2_mux #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            last_q, last_d;
  logic            s_q, s_d;
  logic            hold_sat;

  assign hold_sat = (hold_q == HOLD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b)
          state_d = last_q ? GNT_A : GNT_B;
        else if (req_a)
          state_d = GNT_A;
        else if (req_b)
          state_d = GNT_B;
      end
      GNT_A: begin
        if (!req_a)
          state_d = req_b ? GNT_B : IDLE;
        else if (req_b && hold_sat)
          state_d = GNT_B;
      end
      GNT_B: begin
        if (!req_b)
          state_d = req_a ? GNT_A : IDLE;
        else if (req_a && hold_sat)
          state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tenure counter restarts on every entry into a grant state.
  always_comb begin
    hold_d = '0;
    last_d = last_q;
    s_d    = s_q;
    if (state_d != IDLE) begin
      if (state_d == state_q)
        hold_d = hold_sat ? hold_q : hold_q + HW'(1);
      else
        last_d = (state_d == GNT_B);
      s_d = (state_d == GNT_B);
    end
  end

  assign gnt_a = (state_q == GNT_A);
  assign gnt_b = (state_q == GNT_B);
  assign s     = s_q;
  assign valid = gnt_a | gnt_b;
  assign out   = valid ? (s_q ? b : a) : '0;

endmodule

// File: doc/arb2_mux.md
Name: arb2_mux

Overview:
- Two-requester round-robin arbiter that owns the select line of a 2:1 WIDTH-bit multiplexer.
- Shares one downstream consumer between sources A and B.
- Grants one requester at a time and steers its data to `out`.
- Limits how long a granted requester may hold the resource while the other is waiting.

Parameters:
- WIDTH, 8: data width of a, b and out.
- MAX_HOLD, 4: maximum consecutive grant cycles while the other requester is pending. Legal range ≥2.

Ports:
- clk      in   1      system clock; all state updates on rising edge.
- reset    in   1      asynchronous, active-high reset.
- req_a    in   1      request from source A; held high while A wants the resource.
- req_b    in   1      request from source B.
- a        in   WIDTH  data from source A.
- b        in   WIDTH  data from source B.
- gnt_a    out  1      registered grant to A.
- gnt_b    out  1      registered grant to B.
- s        out  1      registered mux select: 0 = A, 1 = B.
- valid    out  1      gnt_a | gnt_b (combinational from registers).
- out      out  WIDTH  s ? b : a when valid; all-zero when not valid (combinational).

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-high.
  - Asserting reset at any time, including mid-grant, immediately forces: state IDLE, gnt_a=0, gnt_b=0, s=0, valid=0, out=0, hold_cnt=0, last=1.
  - last=1 means "B served last", so A wins the first tie after reset.
- State register: IDLE, GNT_A, GNT_B. gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B. Both grants are never high together.
- Latency: a request is sampled at a rising edge; the grant appears after that same edge (1 cycle from req to gnt). Release is also 1 cycle.
- IDLE:
  - req_a & req_b -> grant the requester ≠ last.
  - Only req_a -> GNT_A.
  - Only req_b -> GNT_B.
  - Neither -> stay in IDLE.
- GNT_A:
  - req_a=0: if req_b=1 -> GNT_B directly (no idle bubble); else -> IDLE.
  - req_a=1, req_b=1, hold_cnt==MAX_HOLD-1 -> GNT_B (preemption).
  - Otherwise stay.
- GNT_B: mirror of GNT_A.
- hold_cnt: clog2(MAX_HOLD) bits.
  - Cleared on every entry into a GNT state and in IDLE.
  - While in a GNT state: increments each cycle; saturates at MAX_HOLD-1.
  - A lone requester therefore holds its grant indefinitely.
- last: updated on entry to GNT_A (last=0) or GNT_B (last=1); unchanged in IDLE.
- s: 0 in GNT_A, 1 in GNT_B; keeps its previous value in IDLE.
- Requests dropping and re-asserting in the same cycle as a switch are evaluated by the rules above at the next edge. No request is latched, so a requester must hold req until granted.
- Width: out is exactly WIDTH bits; no truncation or extension.

Test Plan:
- Reset then single request: reset=1 for 2 cycles, release; req_a=1, a=8'h3C -> one edge later gnt_a=1, s=0, valid=1, out=8'h3C. Drop req_a -> next edge gnt_a=0, out=8'h00.
- Tie after reset: req_a=req_b=1 at the same edge, MAX_HOLD=4 -> gnt_a for 4 cycles, then gnt_b for 4 cycles, alternating. s toggles 0/1 accordingly; out follows a/b.
- Lone holder: only req_b=1 for 20 cycles -> gnt_b stays 1 for all 20. Assert req_a at cycle 10 -> switch to gnt_a no later than MAX_HOLD cycles after req_a is sampled (hold_cnt already saturated at MAX_HOLD-1).
- Direct handoff: in GNT_A, drop req_a while req_b=1 -> next edge gnt_a=0 and gnt_b=1, valid never drops to 0, s=1, out=b.
- Reset mid-grant: gnt_b=1, pulse reset between edges -> gnt_b, valid and out go to 0 immediately without a clock edge. After release with req_a=req_b=1 -> A granted first.
- Exclusivity check: 1000 random cycles of req_a/req_b/a/b -> gnt_a&gnt_b never 1; valid==(gnt_a|gnt_b); out matches the select rule every cycle.
